// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM rule writer.
// Contents: segment width, sweep length, counter width, FSM state type,
// and the per-segment ternary match helper used by the segment encoder.
package tcam_pkg;

    localparam int unsigned SEG_W     = 6;
    localparam int unsigned SWEEP_LEN = 64;
    localparam int unsigned CNT_W     = $clog2(SWEEP_LEN);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // A LUTRAM cell at address key6 holds 1 when key6 matches the rule
    // segment on every cared-for bit.
    function automatic logic seg_match(
        input logic [SEG_W-1:0] key6,
        input logic [SEG_W-1:0] val6,
        input logic [SEG_W-1:0] care6
    );
        return ((key6 ^ val6) & care6) == '0;
    endfunction

endpackage

// File: rtl/tcam_seg_encoder.sv
// Combinational per-segment data generator for one LUTRAM address.
// Ports:
//   key    - LUTRAM address (search-key segment value) being encoded
//   value  - rule value
//   care   - rule care mask (1 = compare)
//   del    - delete request; forces every segment bit to 0
//   data_c - one match bit per 6-bit segment
module tcam_seg_encoder
    import tcam_pkg::*;
#(
    parameter int unsigned WIDTH = 36
) (
    input  logic [CNT_W-1:0]       key,
    input  logic [WIDTH-1:0]       value,
    input  logic [WIDTH-1:0]       care,
    input  logic                   del,
    output logic [WIDTH/SEG_W-1:0] data_c
);

    localparam int unsigned SEGS = WIDTH / SEG_W;

    // Evaluate every segment against the same key; delete clears the entry.
    always_comb begin
        data_c = '0;
        if (!del) begin
            for (int s = 0; s < SEGS; s++) begin
                data_c[s] = seg_match(key,
                                      value[s*SEG_W +: SEG_W],
                                      care[s*SEG_W +: SEG_W]);
            end
        end
    end

endmodule

// File: rtl/tcam_rule_writer.sv
// Update engine for the LUTRAM-based TCAM array.
// Accepts one install/delete request over valid/ready, then sweeps all 64
// LUTRAM addresses of the target entry, one per cycle, while holding
// lookups blocked.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   reqValid/Ready  - request handshake (ready only in IDLE, low in reset)
//   reqDel          - 1 = delete entry, 0 = install rule
//   reqAddr         - target entry
//   reqValue/Care   - ternary rule value and care mask
//   wEn, wAddr      - array write enable and entry address
//   wCnt            - LUTRAM address being written
//   wData           - per-segment data bit for wCnt
//   lkBlock         - lookups invalid while high (mirrors wEn)
//   done            - one-cycle pulse after the last sweep write
module tcam_rule_writer
    import tcam_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reqValid,
    output logic                     reqReady,
    input  logic                     reqDel,
    input  logic [$clog2(DEPTH)-1:0] reqAddr,
    input  logic [WIDTH-1:0]         reqValue,
    input  logic [WIDTH-1:0]         reqCare,
    output logic                     wEn,
    output logic [$clog2(DEPTH)-1:0] wAddr,
    output logic [CNT_W-1:0]         wCnt,
    output logic [WIDTH/SEG_W-1:0]   wData,
    output logic                     lkBlock,
    output logic                     done
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned SEGS   = WIDTH / SEG_W;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                del_q;
    logic [WIDTH-1:0]    value_q;
    logic [WIDTH-1:0]    care_q;

    logic                accept;
    logic                last;
    logic [CNT_W-1:0]    enc_key;
    logic [WIDTH-1:0]    enc_value;
    logic [WIDTH-1:0]    enc_care;
    logic                enc_del;
    logic [SEGS-1:0]     enc_data;

    // Ready is a pure state decode, forced low while reset is asserted.
    assign reqReady = (state == IDLE) && !rst;
    assign accept   = reqValid && reqReady;
    assign last     = (cnt == CNT_W'(SWEEP_LEN - 1));
    assign wCnt     = cnt;

    // wData is registered one step ahead: on accept encode address 0 from the
    // incoming request, otherwise encode the next address from the latched rule.
    assign enc_key   = accept ? '0       : cnt + CNT_W'(1);
    assign enc_value = accept ? reqValue : value_q;
    assign enc_care  = accept ? reqCare  : care_q;
    assign enc_del   = accept ? reqDel   : del_q;

    tcam_seg_encoder #(
        .WIDTH (WIDTH)
    ) u_enc (
        .key    (enc_key),
        .value  (enc_value),
        .care   (enc_care),
        .del    (enc_del),
        .data_c (enc_data)
    );

    // Control FSM with registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            del_q   <= 1'b0;
            value_q <= '0;
            care_q  <= '0;
            wEn     <= 1'b0;
            wAddr   <= '0;
            wData   <= '0;
            lkBlock <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SWEEP;
                        cnt     <= '0;
                        del_q   <= reqDel;
                        value_q <= reqValue;
                        care_q  <= reqCare;
                        wAddr   <= ADDR_W'(reqAddr);
                        wEn     <= 1'b1;
                        lkBlock <= 1'b1;
                        wData   <= enc_data;
                    end
                end
                SWEEP: begin
                    // Counter wraps 63 -> 0 on the final write.
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state   <= IDLE;
                        wEn     <= 1'b0;
                        lkBlock <= 1'b0;
                        wData   <= '0;
                        done    <= 1'b1;
                    end else begin
                        wData <= enc_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_rule_writer.sv
// Self-checking bench for tcam_rule_writer (DEPTH=16, WIDTH=12).
// Each accepted request pushes 64 expected write beats and one done cycle
// onto scoreboard queues; a negedge monitor pops and compares them.
module tb_tcam_rule_writer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 12;
    localparam int unsigned AW    = 4;
    localparam int unsigned SW    = 2;

    logic          clk;
    logic          rst;
    logic          reqValid;
    logic          reqReady;
    logic          reqDel;
    logic [AW-1:0] reqAddr;
    logic [11:0]   reqValue;
    logic [11:0]   reqCare;
    logic          wEn;
    logic [AW-1:0] wAddr;
    logic [5:0]    wCnt;
    logic [SW-1:0] wData;
    logic          lkBlock;
    logic          done;

    tcam_rule_writer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqDel   (reqDel),
        .reqAddr  (reqAddr),
        .reqValue (reqValue),
        .reqCare  (reqCare),
        .wEn      (wEn),
        .wAddr    (wAddr),
        .wCnt     (wCnt),
        .wData    (wData),
        .lkBlock  (lkBlock),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected segment hits: >=0 is the single matching key, -1 all keys, -2 none.
    typedef struct {
        logic          del;
        logic [AW-1:0] addr;
        logic [11:0]   value;
        logic [11:0]   care;
        int            hit0;
        int            hit1;
    } vec_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [5:0]    cnt;
        logic [SW-1:0] data;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_on = 1'b0;
    logic rst_seen = 1'b0;
    exp_t sq[$];
    int   dq[$];
    vec_t vecs[6];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input int hit, input int k);
        if (hit == -1) return 1'b1;
        if (hit == -2) return 1'b0;
        return k == hit;
    endfunction

    // Monitor: compare every cycle against the scoreboard.
    always @(negedge clk) begin : mon
        bit busy;
        bit dn;
        if (mon_on) begin
            if (rst_seen === 1'b1) begin
                chk("rst_wEn",     32'(wEn),     32'd0);
                chk("rst_lkBlock", 32'(lkBlock), 32'd0);
                chk("rst_done",    32'(done),    32'd0);
                chk("rst_wAddr",   32'(wAddr),   32'd0);
                chk("rst_wCnt",    32'(wCnt),    32'd0);
                chk("rst_wData",   32'(wData),   32'd0);
                chk("rst_reqReady", 32'(reqReady), 32'(!rst));
            end else begin
                busy = (sq.size() > 0) && (sq[0].cyc == cyc);
                dn   = (dq.size() > 0) && (dq[0] == cyc);
                chk("wEn",      32'(wEn),      32'(busy));
                chk("lkBlock",  32'(lkBlock),  32'(busy));
                chk("reqReady", 32'(reqReady), 32'(!busy && !rst));
                chk("done",     32'(done),     32'(dn));
                if (busy) begin
                    chk("wAddr", 32'(wAddr), 32'(sq[0].addr));
                    chk("wCnt",  32'(wCnt),  32'(sq[0].cnt));
                    chk("wData", 32'(wData), 32'(sq[0].data));
                    void'(sq.pop_front());
                end
                if (dn) void'(dq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input vec_t v, input int start);
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            e.cyc  = start + k;
            e.addr = v.addr;
            e.cnt  = 6'(k);
            e.data = {exp_bit(v.hit1, k), exp_bit(v.hit0, k)};
            sq.push_back(e);
        end
        dq.push_back(start + 64);
    endtask

    // Present a request (called just after a rising edge); acc = first sweep cycle.
    task automatic send(input vec_t v, input bit hold, output int acc);
        int budget;
        budget   = 300;
        reqDel   = v.del;
        reqAddr  = v.addr;
        reqValue = v.value;
        reqCare  = v.care;
        reqValid = 1'b1;
        while (!reqReady && budget > 0) begin
            step();
            budget--;
        end
        if (!reqReady) begin
            chk("accept_timeout", 32'd0, 32'd1);
            reqValid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            push_exp(v, acc);
            step();
            if (!hold) begin
                reqValid = 1'b0;
                reqDel   = 1'($urandom);
                reqAddr  = AW'($urandom);
                reqValue = 12'($urandom);
                reqCare  = 12'($urandom);
            end
        end
    endtask

    task automatic wait_idle();
        int budget;
        budget = 300;
        while ((sq.size() > 0 || dq.size() > 0) && budget > 0) begin
            step();
            budget--;
        end
        if (sq.size() > 0 || dq.size() > 0) chk("idle_timeout", 32'd0, 32'd1);
        step();
    endtask

    // Drop scoreboard entries scheduled after the current cycle (sweep aborted).
    task automatic flush_future();
        while (sq.size() > 0 && sq[$].cyc > cyc) void'(sq.pop_back());
        while (dq.size() > 0 && dq[$] > cyc) void'(dq.pop_back());
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : main
        int acc_a;
        int acc_b;
        int budget;
        vec_t v;

        vecs[0] = '{1'b0, 4'd5,  12'hABC, 12'hFFF, 32'h3C, 32'h2A};
        vecs[1] = '{1'b0, 4'd3,  12'h540, 12'hFC0, -1,     32'h15};
        vecs[2] = '{1'b1, 4'd15, 12'h5A5, 12'hFFF, -2,     -2};
        vecs[3] = '{1'b0, 4'd0,  12'h000, 12'h000, -1,     -1};
        vecs[4] = '{1'b0, 4'd9,  12'h03F, 12'h03F, 32'h3F, -1};
        vecs[5] = '{1'b0, 4'd12, 12'h000, 12'hFFF, 32'h00, 32'h00};

        rst      = 1'b1;
        reqValid = 1'b0;
        reqDel   = 1'b0;
        reqAddr  = '0;
        reqValue = '0;
        reqCare  = '0;
        step();
        mon_on = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Table-driven single sweeps.
        for (int i = 0; i < 6; i++) begin
            send(vecs[i], 1'b0, acc_a);
            wait_idle();
        end

        // Back-to-back with reqValid held high.
        send(vecs[0], 1'b1, acc_a);
        send(vecs[1], 1'b0, acc_b);
        chk("b2b_spacing", 32'(acc_b - acc_a), 32'd65);
        wait_idle();

        // Request pulsed while busy must be ignored.
        send(vecs[4], 1'b0, acc_a);
        repeat (10) step();
        reqValid = 1'b1;
        reqDel   = 1'b1;
        reqAddr  = 4'd2;
        reqValue = 12'hFFF;
        reqCare  = 12'hFFF;
        step();
        reqValid = 1'b0;
        wait_idle();
        repeat (3) step();

        // Reset mid-sweep at wCnt=30, with reqValid asserted during reset.
        send(vecs[0], 1'b0, acc_a);
        budget = 100;
        while (wCnt != 6'd30 && budget > 0) begin
            step();
            budget--;
        end
        chk("reach_cnt30", 32'(wCnt), 32'd30);
        rst = 1'b1;
        flush_future();
        step();
        reqValid = 1'b1;
        reqDel   = 1'b0;
        reqAddr  = 4'd7;
        reqValue = 12'h123;
        reqCare  = 12'hFFF;
        step();
        reqValid = 1'b0;
        rst      = 1'b0;
        step();
        step();

        // Fresh request after the abort sweeps the full 0..63.
        v = '{1'b0, 4'd6, 12'hABC, 12'hFFF, 32'h3C, 32'h2A};
        send(v, 1'b0, acc_a);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
